phase_sequencer: RTL
====================

# phase_sequencer

Autonomous traffic-light phase generator that produces the 4-bit cycle code and the blink-enable bit consumed by the light decoder. It replaces or backs up the ESP32 as the source of `ciclo_esp32`/`dest_esp32`. It steps through four approaches (green, then amber) on a 1 s time base, and falls back to all-amber flash when disabled.

## Interface
- `CLK_HZ`, 27_000_000: input clock frequency; sets the 1 s tick period.
- `GREEN_S`, 20: green duration per approach, seconds (≥ 2).
- `AMBER_S`, 3: amber duration per approach, seconds (≥ 1).
- `BLINK_S`, 3: final seconds of green with blink enabled (< `GREEN_S`).
- `clk  in  1`: system clock.
- `rst  in  1`: **asynchronous, active-high reset**.
- `en  in  1`: run sequence when 1, flash mode when 0; level-sensitive.
- `skip  in  1`: one-cycle pulse that ends the current green early.
- `ciclo  out  4`: phase code to the decoder (see Operation).
- `dest  out  1`: blink enable for the current green.
- `tick  out  1`: one-cycle strobe at each 1 s boundary; for debug and monitoring.

## Operation
- Phase codes:
  - 0 = flash (all amber).
  - Approach n (n = 0..3) green = 2n+1.
  - Approach n amber = 2n+2.
  - Codes 9..15 are never driven.
- States: FLASH, GREEN, AMBER. The FSM also holds a 2-bit approach index `ap` and a seconds counter `sec`.
- Reset values: state FLASH, `ap`=0, `sec`=0, prescaler 0, `ciclo`=0, `dest`=0, `tick`=0.
- FLASH:
  - `ciclo`=0, `dest`=0.
  - When `en`=1 is sampled: go to GREEN with `ap`=0, `sec`=0, and the prescaler cleared.
- GREEN:
  - `ciclo`=2·`ap`+1.
  - `sec` increments on `tick`.
  - When `tick` arrives with `sec`==`GREEN_S`-1: go to AMBER and clear `sec`.
- AMBER:
  - `ciclo`=2·`ap`+2.
  - When `tick` arrives with `sec`==`AMBER_S`-1: go to GREEN, set `ap`=`ap`+1 (wraps from 3 to 0), clear `sec`.
- Skip: `skip` sampled in GREEN forces AMBER on the next clock, clears `sec` and clears the prescaler. `skip` in FLASH or AMBER is ignored.
- `en`=0 in any state forces FLASH on the next clock, clears `sec`, `ap` and the prescaler. This has priority over `skip` and over `tick` transitions.
- Prescaler: counts 0..`CLK_HZ`-1. `tick` is asserted for the single cycle in which the count equals `CLK_HZ`-1, and the count then wraps to 0. The prescaler is held at 0 in FLASH.
- Arithmetic: `sec` width is $clog2(max(`GREEN_S`,`AMBER_S`)). The prescaler width is $clog2(`CLK_HZ`). All compares are unsigned and exact-equality.

## Timing
- All outputs are registered.
- Each phase code changes exactly one clock after the `tick` (or `skip`/`en` sample) that causes the transition.
- Phase durations, measured from a `tick`-caused entry:
  - Green lasts exactly `GREEN_S`·`CLK_HZ` cycles.
  - Amber lasts exactly `AMBER_S`·`CLK_HZ` cycles.
  - First green after FLASH exit: the same `GREEN_S`·`CLK_HZ`, counted from the clock after `en` is sampled high.
- `dest` changes in the same cycle as `sec` crosses into the blink window. It drops to 0 in the same cycle `ciclo` leaves green.
- If reset is asserted mid-phase, outputs go to reset values immediately (asynchronously). After release, the block resumes from FLASH and needs `en` sampled high to restart.

## Configuration
- `PHASE_SEQ_GREEN_BLINK_EN`:
  - Defined: in GREEN, `dest`=1 while `sec` ≥ `GREEN_S`-`BLINK_S`, otherwise 0.
  - Undefined: `dest` is tied to 0 and the blink-window compare logic is absent. `BLINK_S` is unused.

## Structure
- Package `phase_seq_pkg` holds:
  - `typedef enum logic [1:0] {FLASH, GREEN, AMBER} phase_t`.
  - Constant `CICLO_FLASH` = 4'd0.
  - Function `ciclo_code(phase_t, logic [1:0] ap)` returning the 4-bit code.
- One sub-module, `tick_gen`: parameter `CLK_HZ`; ports `clk`, `rst`, `clr`, `tick`. It contains the prescaler only.

## Test plan
All scenarios use `CLK_HZ`=10, `GREEN_S`=5, `AMBER_S`=2, `BLINK_S`=2, with the macro defined unless stated.
- Reset, then `en`=1 from cycle 5 → `ciclo`=1 at cycle 6. `ciclo`=2 after 50 cycles. `ciclo`=3 after a further 20.
- Full run of 280 cycles → `ciclo` follows 1,2,3,4,5,6,7,8 and then returns to 1 (`ap` wraps).
- Green blink window → `dest`=1 exactly for the last 20 cycles of each green, and `dest`=0 in amber and flash. With the macro undefined, `dest` stays 0 throughout.
- `skip` pulse 12 cycles into approach-0 green → `ciclo`=2 on the next clock. Amber then lasts a full 20 cycles.
- `en`=0 together with `skip`, mid-amber → `ciclo`=0 next clock and `dest`=0. Re-enabling gives `ciclo`=1 (restart at approach 0).
- `rst` pulsed asynchronously mid-green → `ciclo`=0, `dest`=0, `tick`=0 before the next clock edge. Operation stays in FLASH until `en` is sampled high.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// phase_seq_pkg
//
// Shared types and helpers for the traffic-light phase sequencer.
//
// Contents:
//   phase_t      - FSM state encoding (FLASH, GREEN, AMBER)
//   CICLO_FLASH  - phase code driven while flashing all-amber
//   ciclo_code() - maps (state, approach index) to the 4-bit decoder code
//   max_int()    - elaboration-time maximum, used for counter sizing
//   width_of()   - $clog2 clamped to at least one bit
// -----------------------------------------------------------------------------
package phase_seq_pkg;

    typedef enum logic [1:0] {
        FLASH = 2'd0,
        GREEN = 2'd1,
        AMBER = 2'd2
    } phase_t;

    localparam logic [3:0] CICLO_FLASH = 4'd0;

    // Approach n green -> 2n+1, approach n amber -> 2n+2, flash -> 0.
    // The result never exceeds 8, so codes 9..15 cannot be produced.
    function automatic logic [3:0] ciclo_code(input phase_t phase, input logic [1:0] ap);
        logic [3:0] base;
        base = {1'b0, ap, 1'b0};
        case (phase)
            GREEN:   ciclo_code = base + 4'd1;
            AMBER:   ciclo_code = base + 4'd2;
            default: ciclo_code = CICLO_FLASH;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        max_int = (a > b) ? a : b;
    endfunction

    // A counter that must hold 0..n-1 needs $clog2(n) bits; a range of one
    // value would give zero bits, which is not a legal vector width.
    function automatic int width_of(input int n);
        width_of = (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : phase_seq_pkg

// File: rtl/phase_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// One-second time base for the phase sequencer. A prescaler counts
// 0..CLK_HZ-1 and wraps; tick is high for exactly the cycle in which the
// count equals CLK_HZ-1.
//
// Parameters:
//   CLK_HZ - input clock frequency in Hz (cycles per tick)
//
// Ports:
//   clk  in  1 : system clock
//   rst  in  1 : asynchronous active-high reset (count 0, tick 0)
//   clr  in  1 : synchronous clear, count returns to 0 on the next edge
//   tick out 1 : registered one-cycle strobe at each period boundary
// -----------------------------------------------------------------------------
module tick_gen
    import phase_seq_pkg::*;
#(
    parameter int CLK_HZ = 27_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = width_of(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // tick is decoded from the next count so that the registered strobe
        // lines up with the cycle in which cnt_q holds CNT_LAST.
        tick_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : tick_gen

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Autonomous traffic-light phase generator. Produces the 4-bit cycle code and
// blink-enable bit consumed by the light decoder, stepping through four
// approaches (green then amber) on a 1 s time base, and falling back to
// all-amber flash whenever en is low.
//
// Parameters:
//   CLK_HZ  - input clock frequency; one tick every CLK_HZ cycles
//   GREEN_S - green duration per approach in seconds (>= 2)
//   AMBER_S - amber duration per approach in seconds (>= 1)
//   BLINK_S - trailing seconds of green with dest set (< GREEN_S)
//
// Ports:
//   clk   in  1 : system clock
//   rst   in  1 : asynchronous active-high reset
//   en    in  1 : 1 = run the sequence, 0 = flash (level-sensitive)
//   skip  in  1 : one-cycle pulse; ends the current green early
//   ciclo out 4 : phase code (0 flash, 2n+1 green n, 2n+2 amber n)
//   dest  out 1 : blink enable during the final BLINK_S seconds of green
//   tick  out 1 : one-cycle strobe at each 1 s boundary
//
// Build option:
//   PHASE_SEQ_GREEN_BLINK_EN - when defined, dest is raised for the last
//   BLINK_S seconds of each green. When undefined, dest is constant 0 and
//   the blink-window compare is not built.
// -----------------------------------------------------------------------------
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int CLK_HZ  = 27_000_000,
    parameter int GREEN_S = 20,
    parameter int AMBER_S = 3,
    parameter int BLINK_S = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       skip,
    output logic [3:0] ciclo,
    output logic       dest,
    output logic       tick
);

    localparam int               SEC_W      = width_of(max_int(GREEN_S, AMBER_S));
    localparam logic [SEC_W-1:0] GREEN_LAST = SEC_W'(GREEN_S - 1);
    localparam logic [SEC_W-1:0] AMBER_LAST = SEC_W'(AMBER_S - 1);

    phase_t           state_q;
    phase_t           state_d;
    logic [1:0]       ap_q;
    logic [1:0]       ap_d;
    logic [SEC_W-1:0] sec_q;
    logic [SEC_W-1:0] sec_d;
    logic [3:0]       ciclo_q;
    logic [3:0]       ciclo_d;
    logic             dest_q;
    logic             dest_d;

    logic             presc_clr;
    logic             tick_w;

    // -------------------------------------------------------------------------
    // 1 s time base
    // -------------------------------------------------------------------------
    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .tick (tick_w)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ap_d      = ap_q;
        sec_d     = sec_q;
        presc_clr = 1'b0;

        if (!en) begin
            // Disable wins over skip and over any tick-driven transition.
            state_d   = FLASH;
            ap_d      = 2'd0;
            sec_d     = '0;
            presc_clr = 1'b1;
        end else begin
            case (state_q)
                FLASH: begin
                    // Clearing the prescaler here makes the first green last
                    // a full GREEN_S seconds from the clock after en is seen.
                    state_d   = GREEN;
                    ap_d      = 2'd0;
                    sec_d     = '0;
                    presc_clr = 1'b1;
                end

                GREEN: begin
                    if (skip) begin
                        // Prescaler restart gives the following amber its
                        // full length rather than a partial first second.
                        state_d   = AMBER;
                        sec_d     = '0;
                        presc_clr = 1'b1;
                    end else if (tick_w) begin
                        if (sec_q == GREEN_LAST) begin
                            state_d = AMBER;
                            sec_d   = '0;
                        end else begin
                            sec_d = sec_q + SEC_W'(1);
                        end
                    end
                end

                AMBER: begin
                    if (tick_w) begin
                        if (sec_q == AMBER_LAST) begin
                            state_d = GREEN;
                            ap_d    = ap_q + 2'd1;  // wraps 3 -> 0
                            sec_d   = '0;
                        end else begin
                            sec_d = sec_q + SEC_W'(1);
                        end
                    end
                end

                default: begin
                    // Unused encoding: recover into flash.
                    state_d   = FLASH;
                    ap_d      = 2'd0;
                    sec_d     = '0;
                    presc_clr = 1'b1;
                end
            endcase
        end

        // Outputs are computed from the next state so that the registered
        // code changes on the same edge as the state itself.
        ciclo_d = ciclo_code(state_d, ap_d);

`ifdef PHASE_SEQ_GREEN_BLINK_EN
        dest_d = (state_d == GREEN) && (sec_d >= SEC_W'(GREEN_S - BLINK_S));
`else
        dest_d = 1'b0;
`endif
    end

`ifndef PHASE_SEQ_GREEN_BLINK_EN
    // BLINK_S has no effect in this build; this constant keeps the parameter
    // referenced so it does not look like an oversight.
    logic unused_blink_s;
    assign unused_blink_s = (BLINK_S != 0);
`endif

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FLASH;
            ap_q    <= 2'd0;
            sec_q   <= '0;
            ciclo_q <= CICLO_FLASH;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ap_q    <= ap_d;
            sec_q   <= sec_d;
            ciclo_q <= ciclo_d;
            dest_q  <= dest_d;
        end
    end

    assign ciclo = ciclo_q;
    assign dest  = dest_q;
    assign tick  = tick_w;

endmodule : phase_sequencer
